if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one request at a time to instruction memory over a req/ack handshake.
- Presents IF_PC, IF_PCAdd4 and IF_Inst to IF/ID. Substitutes NOP (32'h0) whenever no valid instruction is available.
- Honours the two hazard stalls and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset. Sampled on posedge clock; 0 = reset.
- stall  in  1  hazard stall #1; same signal that gates IF/ID.
- stall2  in  1  hazard stall #2; same signal that gates IF/ID.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- IF_PC  out  32  PC of the presented instruction.
- IF_PCAdd4  out  32  IF_PC+4, mod 2^32.
- IF_Inst  out  32  presented instruction, or 0 (NOP) when IF_valid=0.
- IF_valid  out  1  IF_Inst is a real fetched instruction.

Behaviour:
- Definitions:
  - adv = ~stall & ~stall2 (same enable IF/ID uses).
  - Registers: pc, req_addr, ibuf, state ∈ {REQ, HOLD, DROP}.
- Reset (reset==0 at posedge):
  - pc=req_addr=RESET_PC, ibuf=0, state=REQ.
  - While reset is low, outputs are forced: imem_req=0, IF_valid=0, IF_Inst=0, IF_PC=RESET_PC, IF_PCAdd4=RESET_PC+4.
  - Instruction memory shares this reset, so no transaction survives reset.
  - Reset mid-request abandons the request with no drop phase.
- Handshake contract:
  - Once imem_req=1, imem_addr stays stable until the cycle imem_ack=1.
  - imem_ack is only legal while imem_req=1.
  - Minimum latency is 0 cycles (ack in the same cycle as req).
- REQ:
  - imem_req=1, imem_addr=pc (req_addr tracks pc).
  - IF_valid=imem_ack; IF_Inst=imem_rdata when imem_ack, else 0 (combinational bypass).
  - imem_ack & adv: pc<=pc+4; stay REQ. Throughput is 1 instr/cycle.
  - imem_ack & ~adv: ibuf<=imem_rdata; go to HOLD.
  - ~imem_ack: stay REQ; IF/ID receives a NOP bubble if it is enabled.
- HOLD:
  - imem_req=0, IF_valid=1, IF_Inst=ibuf, IF_PC=pc.
  - adv: pc<=pc+4; go to REQ. Otherwise hold all state.
- DROP:
  - An outstanding request is being discarded.
  - imem_req=1, imem_addr=req_addr (the old address). IF_valid=0, IF_Inst=0, IF_PC=pc.
  - On imem_ack: discard data, req_addr<=pc, go to REQ.
- Redirect (redirect_valid=1) has priority over stalls and ack, in every state:
  - pc<={redirect_pc[31:2],2'b00}, and any fetched or buffered data this cycle is discarded.
  - REQ & ~imem_ack: go to DROP, req_addr unchanged.
  - REQ & imem_ack: go to REQ; new address issued next cycle.
  - HOLD: go to REQ.
  - DROP: stay DROP; latest target wins, and if imem_ack also arrives, go to REQ with the new pc.
- Stall and redirect in the same cycle: redirect wins. The IF/ID flush is the hazard unit's job.
- Arithmetic: pc+4 wraps 32'hFFFF_FFFC → 32'h0000_0000. IF_PCAdd4 uses the same wrap.

Decomposition:
- Shared package:
  - RESET_PC default.
  - NOP_INST=32'h0.
  - State encoding (REQ=2'd0, HOLD=2'd1, DROP=2'd2).
  - Width constant 32.
- One natural sub-module, if_next_pc: combinational next-pc select (redirect / pc+4 / hold).
- The FSM and registers stay in if_fetch_stage.

Test Plan:
- Reset low 2 cycles, then high, with ack each cycle the same cycle as req, adv=1 → imem_addr 0,4,8,C on consecutive cycles; IF_Inst equals rdata every cycle; IF_PCAdd4=IF_PC+4.
- Ack arrives 3 cycles after req for addr 0 → IF_valid=0, IF_Inst=0 for 3 cycles; pc stays 0; imem_addr stable 0.
- Ack for addr 4 with stall=1 for 2 cycles → HOLD: IF_Inst=captured word, imem_req=0, IF_PC=4; after stall drops, next request is addr 8.
- Redirect to 0x100 while req addr 0x10 is pending (no ack) → DROP: imem_addr stays 0x10 until ack, that data is never presented; next request is 0x100.
- Redirect to 0x203 with ack and stall=1 in the same cycle → data discarded, next imem_addr=0x200, IF_valid=0 that cycle.
- RESET_PC=32'hFFFF_FFFC, ack immediate → addresses FFFF_FFFC then 0000_0000; reset asserted mid-stream → next cycle imem_req=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Covers the state encoding, word width, NOP encoding and PC arithmetic helpers.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Forces an address onto a word boundary. Masking keeps every input bit in use.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and imem (slave).
// Handshake: while imem_req=1, imem_addr is held stable until the cycle imem_ack=1. imem_ack is only
// legal while imem_req=1, may arrive in the same cycle as the request, and imem_rdata is valid with it.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_fetch_stage_next_pc.sv
// Next-PC select for the fetch stage.
// A redirect outranks a sequential step, and the stage holds the current PC if neither applies.
module if_next_pc
  import if_fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inc,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = align_word(redirect_pc);
    end else if (inc) begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage that owns the PC and has one imem request in flight at a time.
// It presents a fetched instruction, or a NOP bubble, to the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             stall2,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  if_fetch_stage_if.master imem,
  output logic [XLEN-1:0]  IF_PC,
  output logic [XLEN-1:0]  IF_PCAdd4,
  output logic [XLEN-1:0]  IF_Inst,
  output logic             IF_valid,
  output fetch_state_e     dbg_state
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next, req_addr, ibuf;
  logic            adv, inc;

  assign adv = ~stall & ~stall2;
  assign inc = ~redirect_valid & adv &
               (((state == ST_REQ) & imem.imem_ack) | (state == ST_HOLD));

  if_next_pc u_next_pc (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inc            (inc),
    .next_pc        (pc_next)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_REQ;
    else        state <= state_next;
  end

  // req_addr freezes only while an abandoned request is still being drained.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      ibuf     <= NOP_INST;
    end else begin
      pc <= pc_next;
      if (state_next != ST_DROP) req_addr <= pc_next;
      if ((state == ST_REQ) && imem.imem_ack && !adv && !redirect_valid)
        ibuf <= imem.imem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_REQ: begin
        if (redirect_valid)               state_next = imem.imem_ack ? ST_REQ : ST_DROP;
        else if (imem.imem_ack && !adv)   state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (redirect_valid || adv)        state_next = ST_REQ;
      end
      ST_DROP: begin
        if (imem.imem_ack)                state_next = ST_REQ;
      end
      default:                            state_next = ST_REQ;
    endcase
  end

  // A redirect in any state suppresses whatever would have been presented this cycle.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    IF_PC          = pc;
    IF_valid       = 1'b0;
    IF_Inst        = NOP_INST;
    if (!reset) begin
      imem.imem_addr = RESET_PC;
      IF_PC          = RESET_PC;
    end else begin
      case (state)
        ST_REQ: begin
          imem.imem_req = 1'b1;
          if (imem.imem_ack && !redirect_valid) begin
            IF_valid = 1'b1;
            IF_Inst  = imem.imem_rdata;
          end
        end
        ST_HOLD: begin
          if (!redirect_valid) begin
            IF_valid = 1'b1;
            IF_Inst  = ibuf;
          end
        end
        ST_DROP: begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = req_addr;
        end
        default: ;
      endcase
    end
  end

  assign IF_PCAdd4 = IF_PC + PC_STEP;
  assign dbg_state = state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: default-reset instance plus a wrap-around RESET_PC instance.
// Instructions are pushed to exp_q when acked and popped when IF/ID would accept them.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic clk;
  logic rst_n, stall, stall2, redir_v;
  logic [31:0] redir_pc;
  logic [31:0] if_pc, if_pcadd4, if_inst;
  logic if_valid;
  fetch_state_e dbg0;

  logic rst1_n, stall_1, stall2_1, redir_v_1;
  logic [31:0] redir_pc_1;
  logic [31:0] if_pc_1, if_pcadd4_1, if_inst_1;
  logic if_valid_1;
  fetch_state_e dbg1;

  logic [31:0] exp_q[$];
  int n_cmp, n_err;

  if_fetch_stage_if bus0();
  if_fetch_stage_if bus1();

  if_fetch_stage dut0 (
    .clock(clk), .reset(rst_n), .stall(stall), .stall2(stall2),
    .redirect_valid(redir_v), .redirect_pc(redir_pc), .imem(bus0),
    .IF_PC(if_pc), .IF_PCAdd4(if_pcadd4), .IF_Inst(if_inst), .IF_valid(if_valid),
    .dbg_state(dbg0)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clock(clk), .reset(rst1_n), .stall(stall_1), .stall2(stall2_1),
    .redirect_valid(redir_v_1), .redirect_pc(redir_pc_1), .imem(bus1),
    .IF_PC(if_pc_1), .IF_PCAdd4(if_pcadd4_1), .IF_Inst(if_inst_1), .IF_valid(if_valid_1),
    .dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ {16'h0013, a[31:16]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                       input logic st2, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    bus0.imem_ack = ack; bus0.imem_rdata = rdata;
    stall = st; stall2 = st2; redir_v = rv; redir_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = '0;
    stall = 1'b0; stall2 = 1'b0; redir_v = 1'b0; redir_pc = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      n_cmp++; if (bus0.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus0.imem_req); end
      n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got v=%b %h want v=0 0", if_valid, if_inst); end
      n_cmp++; if (if_pc !== 32'h0 || if_pcadd4 !== 32'h4) begin n_err++; $display("FAIL reset_pc: got %h/%h want 0/4", if_pc, if_pcadd4); end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_release: got req=%b addr=%h want 1/0", bus0.imem_req, bus0.imem_addr); end
    n_cmp++; if (dbg0 !== ST_REQ) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg0, ST_REQ); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(inst_of(exp_pc));
      drive(1'b1, inst_of(exp_pc), 1'b0, 1'b0, 1'b0, '0);
      n_cmp++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== exp_pc) begin n_err++; $display("FAIL stream_addr: got req=%b %h want 1 %h", bus0.imem_req, bus0.imem_addr, exp_pc); end
      n_cmp++; if (if_valid !== 1'b1 || exp_q.size() == 0 || if_inst !== exp_q[0]) begin n_err++; $display("FAIL stream_inst: got v=%b %h want v=1 %h", if_valid, if_inst, exp_q[0]); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n_cmp++; if (if_pc !== exp_pc || if_pcadd4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL stream_pc: got %h/%h want %h/%h", if_pc, if_pcadd4, exp_pc, exp_pc + 32'd4); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, '0);
      n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin n_err++; $display("FAIL lat_bubble: got v=%b %h want v=0 0", if_valid, if_inst); end
      n_cmp++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0 || if_pc !== 32'h0) begin n_err++; $display("FAIL lat_addr: got req=%b addr=%h pc=%h want 1/0/0", bus0.imem_req, bus0.imem_addr, if_pc); end
    end
    exp_q.push_back(inst_of(32'h0));
    drive(1'b1, inst_of(32'h0), 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (if_valid !== 1'b1 || exp_q.size() == 0 || if_inst !== exp_q[0]) begin n_err++; $display("FAIL lat_inst: got v=%b %h want v=1 %h", if_valid, if_inst, exp_q[0]); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (bus0.imem_addr !== 32'h4) begin n_err++; $display("FAIL lat_next: got %h want 00000004", bus0.imem_addr); end
  endtask

  task automatic test_hold();
    logic [31:0] w;
    do_reset();
    exp_q.push_back(inst_of(32'h0));
    drive(1'b1, inst_of(32'h0), 1'b0, 1'b0, 1'b0, '0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    w = $urandom_range(1, 32'h7FFF_FFFF);
    exp_q.push_back(w);
    // captured cycle (stall), held cycle (stall2), release cycle (no stall)
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, w, i == 0, i == 1, 1'b0, '0);
      n_cmp++; if (if_valid !== 1'b1 || exp_q.size() == 0 || if_inst !== exp_q[0]) begin n_err++; $display("FAIL hold_inst%0d: got v=%b %h want v=1 %h", i, if_valid, if_inst, w); end
      n_cmp++; if (if_pc !== 32'h4) begin n_err++; $display("FAIL hold_pc%0d: got %h want 00000004", i, if_pc); end
      if (i > 0) begin
        n_cmp++; if (bus0.imem_req !== 1'b0 || dbg0 !== ST_HOLD) begin n_err++; $display("FAIL hold_req%0d: got req=%b st=%0d want 0/%0d", i, bus0.imem_req, dbg0, ST_HOLD); end
      end
      if (i == 2 && exp_q.size() != 0) void'(exp_q.pop_front());
    end
    exp_q.push_back(inst_of(32'h8));
    drive(1'b1, inst_of(32'h8), 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h8) begin n_err++; $display("FAIL hold_next: got req=%b %h want 1 00000008", bus0.imem_req, bus0.imem_addr); end
    n_cmp++; if (if_valid !== 1'b1 || exp_q.size() == 0 || if_inst !== exp_q[0]) begin n_err++; $display("FAIL hold_after: got v=%b %h want v=1 %h", if_valid, if_inst, exp_q[0]); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_redirect_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(inst_of(32'(i * 4)));
      drive(1'b1, inst_of(32'(i * 4)), 1'b0, 1'b0, 1'b0, '0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h100);
    n_cmp++; if (if_valid !== 1'b0 || bus0.imem_addr !== 32'h10) begin n_err++; $display("FAIL drop_issue: got v=%b addr=%h want 0/00000010", if_valid, bus0.imem_addr); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (dbg0 !== ST_DROP || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h10) begin n_err++; $display("FAIL drop_wait: got st=%0d req=%b addr=%h want %0d/1/00000010", dbg0, bus0.imem_req, bus0.imem_addr, ST_DROP); end
    n_cmp++; if (if_pc !== 32'h100 || if_valid !== 1'b0) begin n_err++; $display("FAIL drop_pc: got %h v=%b want 00000100 v=0", if_pc, if_valid); end
    drive(1'b1, 32'hBAD0_0010, 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || bus0.imem_addr !== 32'h10) begin n_err++; $display("FAIL drop_ack: got v=%b %h addr=%h want 0/0/00000010", if_valid, if_inst, bus0.imem_addr); end
    exp_q.push_back(inst_of(32'h100));
    drive(1'b1, inst_of(32'h100), 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (bus0.imem_addr !== 32'h100 || if_valid !== 1'b1 || exp_q.size() == 0 || if_inst !== exp_q[0]) begin n_err++; $display("FAIL drop_target: got addr=%h v=%b %h want 00000100 v=1 %h", bus0.imem_addr, if_valid, if_inst, exp_q[0]); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_redirect_stall();
    do_reset();
    drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 1'b1, 32'h203);
    n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin n_err++; $display("FAIL rs_discard: got v=%b %h want 0/0", if_valid, if_inst); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (dbg0 !== ST_REQ || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h200 || if_pc !== 32'h200) begin n_err++; $display("FAIL rs_next: got st=%0d req=%b addr=%h pc=%h want %0d/1/00000200/00000200", dbg0, bus0.imem_req, bus0.imem_addr, if_pc, ST_REQ); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    rst1_n = 1'b0; bus1.imem_ack = 1'b0; bus1.imem_rdata = '0;
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++; if (bus1.imem_req !== 1'b0 || if_pc_1 !== 32'hFFFF_FFFC || if_pcadd4_1 !== 32'h0) begin n_err++; $display("FAIL wrap_reset: got req=%b %h/%h want 0 fffffffc/00000000", bus1.imem_req, if_pc_1, if_pcadd4_1); end
    end
    @(negedge clk); rst1_n = 1'b1;
    exp_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.imem_ack = 1'b1; bus1.imem_rdata = inst_of(exp_pc);
      #1;
      n_cmp++; if (bus1.imem_addr !== exp_pc || if_pcadd4_1 !== exp_pc + 32'd4) begin n_err++; $display("FAIL wrap_addr%0d: got %h/%h want %h/%h", i, bus1.imem_addr, if_pcadd4_1, exp_pc, exp_pc + 32'd4); end
      n_cmp++; if (if_valid_1 !== 1'b1 || if_inst_1 !== inst_of(exp_pc)) begin n_err++; $display("FAIL wrap_inst%0d: got v=%b %h want v=1 %h", i, if_valid_1, if_inst_1, inst_of(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst1_n = 1'b0; bus1.imem_ack = 1'b0;
      #1;
      n_cmp++; if (bus1.imem_req !== 1'b0 || if_valid_1 !== 1'b0 || if_pc_1 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_midreset%0d: got req=%b v=%b pc=%h want 0/0/fffffffc", i, bus1.imem_req, if_valid_1, if_pc_1); end
    end
    @(negedge clk); rst1_n = 1'b1; #1;
    n_cmp++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_restart: got req=%b %h want 1 fffffffc", bus1.imem_req, bus1.imem_addr); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; stall = 1'b0; stall2 = 1'b0; redir_v = 1'b0; redir_pc = '0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = '0;
    rst1_n = 1'b0; stall_1 = 1'b0; stall2_1 = 1'b0; redir_v_1 = 1'b0; redir_pc_1 = '0;
    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0;
    test_reset();
    test_stream();
    test_latency();
    test_hold();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
